// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, baud divisor helper and receive FSM encoding.
// The transmit path imports the same package so both sides agree on framing.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so an idle-high
// serial line never looks like a start bit coming out of reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output, framing-error and
// overrun pulses. A stop bit sampled low parks the FSM until the line goes idle again.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 27_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [2:0]       IDX_LAST      = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rx_s)
  );

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  done_q, done_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line at mid start bit so short glitches are rejected.
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            done_d  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // A completed byte may replace the held one only if that one is accepted now.
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: serial frames are driven bit by bit, expected
// bytes are queued at send time and a negedge monitor checks every accepted byte.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int CF   = 16;
  localparam int BD   = 1;
  localparam int CPB  = CF / BD;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_byte #(.CLK_FREQ(CF), .BAUD(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rand_ready = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_near(input string name, input int act, input int req, input int tol);
    checks++;
    if (act < req - tol || act > req + tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/-%0d", name, act, req, tol);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks held bytes stay put.
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", int'(rx_valid), 1);
          check("hold_data", int'(rx_data), int'(prev_data));
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && rx_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte: got 0x%0h expected none (cycle %0d)", rx_data, cyc);
          end else begin
            e = exp_q.pop_front();
            if (rx_data != e) begin
              failures++;
              $display("FAIL rx_byte: got 0x%0h expected 0x%0h (cycle %0d)", rx_data, e, cyc);
            end else begin
              $display("byte 0x%02h accepted at cycle %0d", rx_data, cyc);
            end
          end
        end
        prev_hold = rx_valid && !rx_ready;
        prev_data = rx_data;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready != 0) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Drive the line for n clocks; always returns 1 ns after a posedge.
  task automatic drive_bit(input logic b, input int n);
    uart_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(stop, CPB);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int fe0, ov0, t0, rise;
    string s;
    logic [7:0] d;
    logic bad;
    int fe_exp;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_data", int'(rx_data), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_ovr", int'(overrun), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_bit(1'b1, 2 * CPB);

    // Single byte with latency measurement.
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h48);
    t0 = cyc + 1;
    rise = -1;
    fork
      send_frame(8'h48, 1'b1);
      begin
        for (int i = 0; i < 400 && rise < 0; i++) begin
          @(negedge clk);
          if (rx_valid) rise = cyc;
        end
        @(negedge clk);
        check("single_valid_pulse", int'(rx_valid), 0);
      end
    join
    check_near("latency", rise - t0, LAT, 1);
    drive_bit(1'b1, CPB);
    check("single_drained", exp_q.size(), 0);
    check("single_ferr", fe_cnt - fe0, 0);
    check("single_ovr", ov_cnt - ov0, 0);

    // Back-to-back stream.
    s = "Hello, world!";
    for (int i = 0; i < s.len(); i++) begin
      exp_q.push_back(s[i]);
      send_frame(s[i], 1'b1);
    end
    exp_q.push_back(8'h0D); send_frame(8'h0D, 1'b1);
    exp_q.push_back(8'h0A); send_frame(8'h0A, 1'b1);
    drive_bit(1'b1, 3 * CPB);
    check("stream_drained", exp_q.size(), 0);
    check("stream_ferr", fe_cnt - fe0, 0);
    check("stream_ovr", ov_cnt - ov0, 0);

    // Glitch: a 3-clock low pulse must be rejected, then a normal byte still arrives.
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 3 * CPB);
    check("glitch_no_byte", exp_q.size(), 0);
    check("glitch_ferr", fe_cnt - fe0, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    check("after_glitch_drained", exp_q.size(), 0);

    // Framing error followed by a held-low line, then a good byte.
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, CPB);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    check("framing_err_count", fe_cnt - fe0, 1);
    check("framing_drained", exp_q.size(), 0);

    // Overrun: second byte dropped while the first is unaccepted.
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive_bit(1'b1, CPB);
    check("overrun_count", ov_cnt - ov0, 1);
    @(negedge clk);
    check("overrun_held_valid", int'(rx_valid), 1);
    check("overrun_held_data", int'(rx_data), 8'h11);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(negedge clk);
    check("overrun_valid_drop", int'(rx_valid), 0);
    check("overrun_data_kept", int'(rx_data), 8'h11);
    check("overrun_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // Randomized frames with random consumer readiness and occasional bad stop bits.
    fe0 = fe_cnt; ov0 = ov_cnt; fe_exp = 0;
    rand_ready = 1;
    for (int n = 0; n < 20; n++) begin
      int gap;
      d = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      gap = $urandom_range(0, 20);
      if (bad) begin
        fe_exp++;
        send_frame(d, 1'b0);
        drive_bit(1'b0, $urandom_range(10, 50));
        drive_bit(1'b1, CPB);
      end else begin
        exp_q.push_back(d);
        send_frame(d, 1'b1);
      end
      if (gap > 0) drive_bit(1'b1, gap);
    end
    rand_ready = 0;
    @(posedge clk); #1;
    rx_ready = 1'b1;
    drive_bit(1'b1, 3 * CPB);
    check("random_drained", exp_q.size(), 0);
    check("random_ferr", fe_cnt - fe0, fe_exp);
    check("random_ovr", ov_cnt - ov0, 0);

    // Reset during data bit 3 with a byte still pending.
    rx_ready = 1'b0;
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    drive_bit(1'b1, CPB);
    @(negedge clk);
    check("pre_reset_valid", int'(rx_valid), 1);
    @(posedge clk); #1;
    d = 8'h96;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(d[i], CPB);
    uart_rx = d[3];
    repeat (HALF) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    uart_rx = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_valid", int'(rx_valid), 0);
    check("midreset_data", int'(rx_data), 0);
    check("midreset_ferr", int'(frame_err), 0);
    check("midreset_ovr", int'(overrun), 0);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    drive_bit(1'b1, 3 * CPB);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    check("post_reset_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
